// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================
// Package : pipe_pkg
// Shared pipeline constants: widths, bubble control, ctrl fields.
// Rev     : 1.0
// ============================================================
package pipe_pkg;

  localparam int C_DEFAULT_DATA_W = 64;
  localparam int C_DEFAULT_CTRL_W = 8;
  localparam int C_DEFAULT_CNT_W  = 16;

  localparam logic [C_DEFAULT_CTRL_W-1:0] C_NOP_CTRL = 8'h00;

  // Control-field bit positions
  localparam int C_CTRL_ALUSRC   = 0;
  localparam int C_CTRL_LOWER    = 1;
  localparam int C_CTRL_HIGHER   = 2;
  localparam int C_CTRL_WREG_LSB = 3;
  localparam int C_CTRL_WREG_MSB = 6;
  localparam int C_CTRL_RESERVED = 7;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_latch_if.sv
`default_nettype none
// ============================================================
// Interface : pipe_stage_latch_if
// Handshake, payload and statistics bundle of one pipeline stage.
// Rev       : 1.0
// ============================================================
interface pipe_stage_latch_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = C_DEFAULT_DATA_W,
  parameter int CTRL_W = C_DEFAULT_CTRL_W,
  parameter int CNT_W  = C_DEFAULT_CNT_W
);

  logic              stall;
  logic              flush;
  logic              valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  squash_cnt;

  // Upstream / hazard-control side
  modport master (
    output stall, flush, valid_in, ctrl_in, data_in,
    input  valid_out, ctrl_out, data_out, stall_cnt, squash_cnt
  );

  // The stage register itself
  modport slave (
    input  stall, flush, valid_in, ctrl_in, data_in,
    output valid_out, ctrl_out, data_out, stall_cnt, squash_cnt
  );

endinterface : pipe_stage_latch_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================
// Module : sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================
module sat_counter #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         inc,
  output logic      [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_latch.sv
`default_nettype none
// ============================================================
// Module : pipe_stage_latch
// Inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) with stall/flush.
// Rev    : 1.0
// ============================================================
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = C_DEFAULT_DATA_W,
  parameter int                CTRL_W   = C_DEFAULT_CTRL_W,
  parameter logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(C_NOP_CTRL),
  parameter int                CNT_W    = C_DEFAULT_CNT_W
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_stage_latch_if.slave  bus
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              stall_inc;
  logic              squash_inc;

  // Flush beats stall beats load; reset is applied in the register below.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ctrl_d  = NOP_CTRL;
      data_d  = '0;
    end else if (!bus.stall) begin
      valid_d = bus.valid_in;
      data_d  = bus.data_in;
      ctrl_d  = bus.valid_in ? bus.ctrl_in : NOP_CTRL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= NOP_CTRL;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  // A squash only counts when a real instruction is thrown away.
  assign stall_inc  = bus.stall && !bus.flush;
  assign squash_inc = bus.flush && valid_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (squash_inc),
    .count (bus.squash_cnt)
  );

  assign bus.valid_out = valid_q;
  assign bus.ctrl_out  = ctrl_q;
  assign bus.data_out  = data_q;

endmodule : pipe_stage_latch
`default_nettype wire
